// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: formats ALU addresses and store data for a
// variable-latency data port and returns extended load data or a fault.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    input  logic        resp_ready,
    output logic [1:0]  dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid and its payload stay stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    cap_size;
    logic [1:0]    cap_lane;
    logic          cap_unsigned;
    logic          misaligned;
    logic [31:0]   wdata_fmt;
    logic [3:0]    wstrb_fmt;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_ext;

    assign req_ready  = (state == S_IDLE) && !rst;
    assign mem_req    = (state == S_MEM);
    assign resp_valid = (state == S_RESP);
    assign dbg_state  = state;

    always_comb begin
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        case (req_size)
            2'b00: begin
                wdata_fmt = {4{req_wdata[7:0]}};
                wstrb_fmt = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                wdata_fmt = {2{req_wdata[15:0]}};
                wstrb_fmt = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_fmt = req_wdata;
                wstrb_fmt = 4'b1111;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[{cap_lane, 3'b000} +: 8];
        ld_half = cap_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (cap_size)
            2'b00:   load_ext = {{24{~cap_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = {{16{~cap_unsigned & ld_half[15]}}, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid) state_nxt = misaligned ? S_RESP : S_MEM;
            S_MEM:  if (mem_ack || cnt == T_LAST) state_nxt = S_RESP;
            S_RESP: if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            cap_size     <= 2'b00;
            cap_lane     <= 2'b00;
            cap_unsigned <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0;
            mem_wdata    <= 32'h0;
            mem_wstrb    <= 4'h0;
            resp_data    <= 32'h0;
            resp_fault   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    cnt          <= '0;
                    cap_size     <= req_size;
                    cap_lane     <= req_addr[1:0];
                    cap_unsigned <= req_unsigned;
                    if (misaligned) begin
                        resp_data  <= 32'h0;
                        resp_fault <= 1'b1;
                    end else begin
                        mem_we    <= req_we;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= wdata_fmt;
                        mem_wstrb <= req_we ? wstrb_fmt : 4'b0000;
                    end
                end
                S_MEM: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (mem_ack) begin
                        resp_data  <= mem_we ? 32'h0 : load_ext;
                        resp_fault <= 1'b0;
                    end else if (cnt == T_LAST) begin
                        resp_data  <= 32'h0;
                        resp_fault <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses against a
// byte-lane reference model, with a response scoreboard and a memory responder.
module tb_load_store_unit;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic        resp_ready = 1'b0;
    logic [1:0]  dbg_state;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_fault(resp_fault), .resp_ready(resp_ready),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } mem_txn_t;

    logic [32:0] exp_q[$];
    mem_txn_t    exp_mem_q[$];
    int          exp_len_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] cur_rdata = 32'h0;
    int          cur_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic report();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    task automatic abort(input string name);
        n_fail++;
        $display("FAIL %s: bound expired", name);
        report();
        $finish;
    endtask

    // Reference model: response word {fault, data}.
    function automatic logic [32:0] model_resp(input logic we, input logic [1:0] size,
                                               input logic uns, input logic [31:0] addr,
                                               input logic [31:0] rdata, input int wait_c);
        int unsigned nbytes = 1 << size;
        int unsigned bits;
        logic [31:0] mask, v;
        if (size == 2'd3 || (addr % nbytes) != 0) return {1'b1, 32'h0};
        if (wait_c < 0 || wait_c >= T) return {1'b1, 32'h0};
        if (we) return {1'b0, 32'h0};
        if (size == 2'd2) return {1'b0, rdata};
        bits = nbytes * 8;
        mask = (32'h1 << bits) - 32'h1;
        v = (rdata >> ((addr % 4) * 8)) & mask;
        if (!uns && v[bits-1]) v = v | ~mask;
        return {1'b0, v};
    endfunction

    function automatic mem_txn_t model_mem(input logic we, input logic [1:0] size,
                                           input logic [31:0] addr, input logic [31:0] w);
        mem_txn_t t;
        int unsigned nbytes = 1 << size;
        t.we   = we;
        t.addr = addr & 32'hFFFF_FFFC;
        if (size == 2'd0)      t.wdata = (w & 32'hFF) * 32'h0101_0101;
        else if (size == 2'd1) t.wdata = (w & 32'hFFFF) * 32'h0001_0001;
        else                   t.wdata = w;
        t.strb = we ? 4'(((1 << nbytes) - 1) << (addr % 4)) : 4'h0;
        return t;
    endfunction

    function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || ((addr % (1 << size)) != 0);
    endfunction

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {31'h0, resp_valid}, 32'h0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("resp_data", resp_data, e[31:0]);
                check("resp_fault", {31'h0, resp_fault}, {31'h0, e[32]});
            end
        end
    end

    // Memory responder: acks after cur_wait wait cycles, checks the request
    // fields every cycle and the length of each mem_req burst.
    always begin : responder
        int run;
        bit prev;
        bit hit;
        @(posedge clk); #1;
        if (rst) begin
            run = 0; prev = 0; mem_ack = 1'b0;
            exp_mem_q.delete();
            exp_len_q.delete();
        end else begin
            if (prev && !mem_req) begin
                if (exp_len_q.size() != 0) check("mem_req_cycles", run, exp_len_q.pop_front());
                if (exp_mem_q.size() != 0) void'(exp_mem_q.pop_front());
                run = 0;
            end
            if (mem_req) begin
                if (exp_mem_q.size() == 0) begin
                    check("unexpected_mem_req", {31'h0, mem_req}, 32'h0);
                end else begin
                    check("mem_addr", mem_addr, exp_mem_q[0].addr);
                    check("mem_we", {31'h0, mem_we}, {31'h0, exp_mem_q[0].we});
                    check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, exp_mem_q[0].strb});
                    if (exp_mem_q[0].we) check("mem_wdata", mem_wdata, exp_mem_q[0].wdata);
                end
                hit = (run == cur_wait);
                run++;
                mem_ack = hit;
                mem_rdata = hit ? cur_rdata : $urandom;
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
            prev = mem_req;
        end
    end

    task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int wait_c, input int hold);
        logic [32:0] e;
        int k, lat, exp_lat, len;
        bit mis;
        e = model_resp(we, size, uns, addr, rdata, wait_c);
        mis = is_mis(size, addr);
        len = (wait_c < 0 || wait_c >= T) ? T : wait_c + 1;
        exp_lat = mis ? 1 : len + 1;
        exp_q.push_back(e);
        if (!mis) begin
            exp_mem_q.push_back(model_mem(we, size, addr, wdata));
            exp_len_q.push_back(len);
        end
        cur_rdata = rdata;
        cur_wait = wait_c;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        if (!req_ready) abort("req_ready_wait");
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom_range(0, 3)); req_we = 1'($urandom); req_unsigned = 1'($urandom);
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 64) begin @(negedge clk); lat++; end
        if (!resp_valid) abort("resp_valid_wait");
        check("latency", lat, exp_lat);
        repeat (hold) begin
            @(posedge clk); #1;
            req_valid = 1'b1; req_addr = $urandom & 32'hFFFF_FFFC; req_size = 2'd2;
            @(negedge clk);
            check("held_valid", {31'h0, resp_valid}, 32'h1);
            check("held_data", resp_data, e[31:0]);
            check("ready_in_resp", {31'h0, req_ready}, 32'h0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("ready_after_hs", {31'h0, req_ready}, 32'h1);
        check("valid_after_hs", {31'h0, resp_valid}, 32'h0);
    endtask

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        report();
        $fatal(1);
    end

    initial begin : main
        int cnt_v;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_state", {30'h0, dbg_state}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {31'h0, req_ready}, 32'h1);

        do_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 0, 0);
        do_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 0, 0);
        do_access(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD, 32'h0, 3, 0);
        do_access(1'b0, 2'd2, 1'b0, 32'h105, 32'h0, 32'h0, 0, 0);
        do_access(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 0, 0);
        do_access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'hCAFE_F00D, -1, 0);
        do_access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'hCAFE_F00D, 15, 0);
        do_access(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'hBEEF_0000, 0, 5);
        do_access(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'hBEEF_0000, 1, 0);

        // Reset in the middle of a memory access: outputs clear, no response.
        exp_mem_q.push_back(model_mem(1'b0, 2'd2, 32'h40, 32'h0));
        exp_len_q.push_back(0);
        cur_wait = -1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mem_req_before_rst", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        #1;
        check("arst_mem_req", {31'h0, mem_req}, 32'h0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_mem_we_strb", {27'h0, mem_we, mem_wstrb}, 32'h0);
        check("arst_mem_wdata", mem_wdata, 32'h0);
        check("arst_resp", {resp_valid, resp_fault, resp_data[29:0]}, 32'h0);
        check("arst_req_ready", {31'h0, req_ready}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt_v = 0;
        resp_ready = 1'b1;
        repeat (6) begin @(negedge clk); if (resp_valid) cnt_v++; end
        resp_ready = 1'b0;
        check("no_resp_after_rst", cnt_v, 0);
        do_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h1357_9BDF, 2, 0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] sz;
            logic [31:0] a;
            int r, w;
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
            r = $urandom_range(0, 19);
            w = (r < 16) ? r % 5 : (r == 16) ? -1 : (r == 17) ? 15 : (r == 18) ? 16 : 0;
            do_access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, w,
                      $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        report();
        $finish;
    end
endmodule
